// File: rtl/battleship_pkg.sv
// Shared types, board limits and helpers for the shot/score interface.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package battleship_pkg;

  typedef enum logic [1:0] {
    RES_MISS = 2'b00,
    RES_NEAR = 2'b01,
    RES_HIT  = 2'b10
  } shot_result_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    SEND     = 2'd2,
    WAIT_RES = 2'd3
  } launcher_state_t;

  localparam logic [3:0] COORD_MIN = 4'd1;
  localparam logic [3:0] COORD_MAX = 4'd10;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  // True when a single coordinate lies on the 10x10 board.
  function automatic logic coord_ok(input logic [3:0] c);
    return (c >= COORD_MIN) && (c <= COORD_MAX);
  endfunction

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Linear cell number 0..99 for on-board coordinates (row-major, 1-based inputs).
  function automatic logic [6:0] cell_index(input logic [3:0] cx, input logic [3:0] cy);
    logic [6:0] row;
    logic [6:0] col;
    row = {3'b000, cy} - 7'd1;
    col = {3'b000, cx} - 7'd1;
    return (row * 7'd10) + col;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the raw active-low FIRE key; emits one pulse per press.
// Latency: pulse 2 sync cycles + DEBOUNCE_CYCLES stable samples + 1 cycle after the key settles.
// Backpressure: none; the pulse is not held, the consumer must act on it in that cycle.
//
// Ports: clock, reset_L (async active-low), fire_L (raw key, asynchronous),
//        fire_pulse (1-cycle strobe on released->pressed of the debounced level).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_L,
  input  logic fire_L,
  output logic fire_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;   // debounced key level, 1 = released
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = fire_L;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // The counter only runs while the synchronized sample disagrees with the
    // debounced level; any agreeing sample restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_q & ~level_d;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fire_pulse = pulse_q;

endmodule

// File: rtl/shot_launcher.sv
// Turns a debounced FIRE press plus X/Y/big switches into one validated shot for the scorer.
// Latency: shot_valid two cycles after the internal fire pulse; result retires the shot.
// Backpressure: shot_valid/payload held until shot_ready; presses while busy are dropped.
//
// Ports: clock, reset_L (async active-low); fire_L raw key; x/y/big shot switches;
//        shot_valid/shot_ready/shot_x/shot_y/shot_big to scorer; result_valid/result back;
//        last_result, bad_shot, big_left, hit_bcd (two BCD digits), busy status.
// Build option: define SHOT_REPEAT_CHECK_EN to reject shots at already-fired cells.
module shot_launcher
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BIG_BOMBS_INIT  = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       fire_L,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       big,
  output logic       shot_valid,
  input  logic       shot_ready,
  output logic [3:0] shot_x,
  output logic [3:0] shot_y,
  output logic       shot_big,
  input  logic       result_valid,
  input  logic [1:0] result,
  output logic [1:0] last_result,
  output logic       bad_shot,
  output logic [1:0] big_left,
  output logic [7:0] hit_bcd,
  output logic       busy
);

  localparam logic [1:0] BIG_INIT = (BIG_BOMBS_INIT > 3) ? 2'd3 : 2'(BIG_BOMBS_INIT);

  logic fire_pulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond (
    .clock      (clock),
    .reset_L    (reset_L),
    .fire_L     (fire_L),
    .fire_pulse (fire_pulse)
  );

  launcher_state_t state_q, state_d;
  logic [3:0]      shot_x_q, shot_x_d;
  logic [3:0]      shot_y_q, shot_y_d;
  logic            shot_big_q, shot_big_d;
  shot_result_t    last_result_q, last_result_d;
  logic            bad_shot_q, bad_shot_d;
  logic [1:0]      big_left_q, big_left_d;
  logic [7:0]      hit_bcd_q, hit_bcd_d;
  logic            coords_ok;
  logic            repeat_hit;
  logic            illegal;

`ifdef SHOT_REPEAT_CHECK_EN
  logic [99:0] map_q, map_d;
  logic [6:0]  cell_idx;
`endif

  always_comb begin
    state_d       = state_q;
    shot_x_d      = shot_x_q;
    shot_y_d      = shot_y_q;
    shot_big_d    = shot_big_q;
    last_result_d = last_result_q;
    bad_shot_d    = bad_shot_q;
    big_left_d    = big_left_q;
    hit_bcd_d     = hit_bcd_q;
    coords_ok     = coord_ok(shot_x_q) && coord_ok(shot_y_q);
`ifdef SHOT_REPEAT_CHECK_EN
    map_d      = map_q;
    cell_idx   = cell_index(shot_x_q, shot_y_q);
    // Gate on coords_ok so an off-board shot never indexes past the map.
    repeat_hit = coords_ok && map_q[cell_idx];
`else
    repeat_hit = 1'b0;
`endif
    illegal = !coords_ok || (shot_big_q && (big_left_q == 2'd0)) || repeat_hit;

    unique case (state_q)
      IDLE: begin
        if (fire_pulse) begin
          shot_x_d   = x;
          shot_y_d   = y;
          shot_big_d = big;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          bad_shot_d = 1'b1;
          state_d    = IDLE;
        end else begin
          bad_shot_d = 1'b0;
          // Legality already guarantees a nonzero budget for a big shot.
          if (shot_big_q) begin
            big_left_d = big_left_q - 2'd1;
          end
          state_d = SEND;
        end
      end
      SEND: begin
        if (shot_ready) begin
`ifdef SHOT_REPEAT_CHECK_EN
          map_d[cell_idx] = 1'b1;
`endif
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (result_valid) begin
          last_result_d = (result == 2'b11) ? RES_MISS : shot_result_t'(result);
          if (result == RES_HIT) begin
            hit_bcd_d = bcd_inc_sat(hit_bcd_q);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      shot_x_q      <= 4'd0;
      shot_y_q      <= 4'd0;
      shot_big_q    <= 1'b0;
      last_result_q <= RES_MISS;
      bad_shot_q    <= 1'b0;
      big_left_q    <= BIG_INIT;
      hit_bcd_q     <= 8'h00;
`ifdef SHOT_REPEAT_CHECK_EN
      map_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
      shot_big_q    <= shot_big_d;
      last_result_q <= last_result_d;
      bad_shot_q    <= bad_shot_d;
      big_left_q    <= big_left_d;
      hit_bcd_q     <= hit_bcd_d;
`ifdef SHOT_REPEAT_CHECK_EN
      map_q         <= map_d;
`endif
    end
  end

  assign shot_valid  = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign shot_big    = shot_big_q;
  assign last_result = last_result_q;
  assign bad_shot    = bad_shot_q;
  assign big_left    = big_left_q;
  assign hit_bcd     = hit_bcd_q;

endmodule

// File: doc/shot_launcher.md
Name: shot_launcher

Overview:
- Initiator side of the shot/score interface. It turns a raw player FIRE button plus X/Y/big switches into one validated shot transaction for the scoring responder.
- Tracks the remaining big-bomb budget and a BCD hit counter. Flags illegal shots on bad_shot, which drives the HEX6/HEX7 error display.
- Sits between the board-level switch/key inputs and the hit-scoring block. hit_bcd feeds the HEX0/HEX1 seven-segment controls.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before the conditioned button level changes.
- BIG_BOMBS_INIT, 2: big-bomb budget loaded at reset (max 3).

Ports:
- clock  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- fire_L  in  1  raw FIRE key, active-low, asynchronous to clock
- x  in  4  target column, legal 1..10
- y  in  4  target row, legal 1..10
- big  in  1  request a big bomb for this shot
- shot_valid  out  1  shot payload valid to scorer
- shot_ready  in  1  scorer accepts payload
- shot_x  out  4  latched column
- shot_y  out  4  latched row
- shot_big  out  1  latched big flag
- result_valid  in  1  scorer result strobe
- result  in  2  00 miss, 01 near-miss, 10 hit, 11 reserved
- last_result  out  2  most recent result
- bad_shot  out  1  last attempted shot was illegal
- big_left  out  2  remaining big bombs
- hit_bcd  out  8  hit count, two BCD digits [7:4] tens, [3:0] ones
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, reset_L=0) puts everything in a known state:
  - State IDLE; shot_valid, shot_x, shot_y, shot_big, last_result, bad_shot, hit_bcd and busy all 0.
  - big_left = BIG_BOMBS_INIT; conditioned button = released; debounce counter = 0.
  - Reset mid-transaction abandons the shot; the scorer must also be reset.
- Button conditioning:
  - fire_L passes through a 2-flop synchronizer.
  - The conditioned level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples that differ from the current conditioned level.
  - fire_pulse is a 1-cycle pulse on the conditioned released->pressed transition. Holding the key gives exactly one pulse.
- FSM states are IDLE, CHECK, SEND and WAIT_RES.
  - IDLE: fire_pulse in cycle N latches x, y and big into the shot registers; go to CHECK.
  - CHECK (cycle N+1), illegal shot when x<1, x>10, y<1, y>10, or big=1 with big_left=0:
    - bad_shot <= 1; go to IDLE.
  - CHECK (cycle N+1), legal shot:
    - bad_shot <= 0.
    - If big, big_left decrements by 1; it never goes below 0.
    - Go to SEND.
  - SEND: shot_valid=1 from cycle N+2. Payload is held stable while valid.
    - Transfer occurs in the cycle where shot_valid && shot_ready; go to WAIT_RES next cycle.
    - shot_valid drops the cycle after the transfer.
  - WAIT_RES: on result_valid, last_result <= result (11 is stored as 00); go to IDLE.
    - If result==10, hit_bcd increments in BCD: ones 9->0 with tens +1.
    - hit_bcd saturates at 8'h99.
- Events outside their state:
  - fire_pulse while not IDLE is dropped, not queued.
  - result_valid outside WAIT_RES is ignored.
  - shot_ready outside SEND is ignored.
- bad_shot holds its value until the next CHECK.

Optional Feature:
- Macro: SHOT_REPEAT_CHECK_EN.
- Defined:
  - A 100-bit fired-cell map indexed (y-1)*10+(x-1), cleared on reset.
  - CHECK also flags illegal any cell already marked.
  - The cell is marked on the shot_valid/shot_ready transfer.
  - Big shots mark only the centre cell.
- Not defined: no map; repeat shots are legal.

Decomposition:
- Package battleship_pkg holds:
  - shot_result_t enum {RES_MISS=2'b00, RES_NEAR=2'b01, RES_HIT=2'b10}
  - launcher_state_t enum {IDLE, CHECK, SEND, WAIT_RES}
  - COORD_MIN=1, COORD_MAX=10
  - BCD_MAX=8'h99
- One sub-module, button_conditioner, containing the synchronizer, debounce counter and falling-edge pulse. It is parameterized by DEBOUNCE_CYCLES.

Test Plan:
- Reset, then press fire_L for 40 cycles with x=3, y=4, big=0 and shot_ready=1:
  - exactly one transfer with shot_x=3, shot_y=4;
  - shot_valid rises 2 cycles after fire_pulse;
  - busy stays high until result_valid.
- fire_L toggling every 5 cycles (bounce, DEBOUNCE_CYCLES=16) -> no fire_pulse, no transaction.
- Press with x=0, then with y=11:
  - bad_shot=1 and no shot_valid in each case;
  - a following legal press (5,5) clears bad_shot.
- BIG_BOMBS_INIT=2 and three legal big shots:
  - big_left goes 2->1->0;
  - the third shot gives bad_shot=1 with big_left=0.
- Ten shots each answered with result=10 -> hit_bcd=8'h10. Preload to 8'h99, then one more hit -> hit_bcd stays 8'h99.
- Hold shot_ready=0 for 10 cycles and press fire again during SEND:
  - shot_valid and payload stay stable;
  - the extra press is dropped;
  - only one transfer occurs after shot_ready=1.
